// File: rtl/orange_pkg.sv
// Shared types and constants for the digit classifier and its sequencer.
package orange_pkg;

    // Sequencer states. IDLE waits for start, CHECK validates the range,
    // SCAN walks one code per cycle, DONE holds the one-cycle done pulse.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Highest code the classifier treats as legal.
    localparam int unsigned MAX_CODE = 11;

    // Bit n set means code n is prime: {2,3,5,7,11}.
    localparam logic [15:0] PRIME_MASK = 16'h08AC;

    // Bit n set means code n is a non-zero multiple of three: {3,6,9}.
    localparam logic [15:0] DIV3_MASK = 16'h0248;

    // A range is rejected when it is reversed or runs past the last legal code.
    function automatic logic range_bad(input logic [3:0] first,
                                       input logic [3:0] last,
                                       input logic [3:0] max_code);
        return (first > last) || (last > max_code);
    endfunction

endpackage

// File: rtl/orange_digit_class.sv
// Combinational 4-bit digit classifier: prime flag and divisible-by-3 flag.
// Codes 12..15 fall on zero bits of both masks, so they classify as 0/0.
module orange_digit_class
    import orange_pkg::*;
(
    input  logic [3:0] code_i,
    output logic       p_o,
    output logic       d_o
);

    // Table lookup into the constant masks; every code has a defined result.
    assign p_o = PRIME_MASK[code_i];
    assign d_o = DIV3_MASK[code_i];

endmodule

// File: rtl/orange_class_seq.sv
// Range sequencer for the digit classifier. On an accepted start it checks
// the captured range, walks the classifier one code per cycle and counts
// prime and multiple-of-3 codes, then pulses done for one cycle.
//
// Control protocol: start is a request sampled only while idle (there is no
// ready; requests outside IDLE are dropped, never queued). busy is high from
// the cycle after acceptance until the scan ends. done is a one-cycle pulse
// with err and the counts valid alongside it; they hold until the next
// accepted start. abort cancels CHECK or SCAN without a done pulse.
module orange_class_seq
    import orange_pkg::*;
#(
    parameter int unsigned W_CNT    = 4,
    parameter int unsigned MAX_CODE = orange_pkg::MAX_CODE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       lo,
    input  logic [3:0]       hi,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       cur,
    output logic [W_CNT-1:0] prime_cnt,
    output logic [W_CNT-1:0] div3_cnt
);

    // The counts must hold 5 primes; narrower widths are rejected outright.
    if (W_CNT < 3) begin : g_w_cnt_check
        $error("orange_class_seq: W_CNT must be at least 3");
    end

    localparam logic [3:0] MAX_CODE_4 = 4'(MAX_CODE);

    state_e           state_q, state_d;
    logic [3:0]       lo_q, lo_d;
    logic [3:0]       hi_q, hi_d;
    logic [3:0]       cur_q, cur_d;
    logic [W_CNT-1:0] prime_cnt_q, prime_cnt_d;
    logic [W_CNT-1:0] div3_cnt_q, div3_cnt_d;
    logic             err_q, err_d;

    logic             prime_hit;
    logic             div3_hit;

    // The classifier input is driven only from the code register.
    orange_digit_class u_class (
        .code_i (cur_q),
        .p_o    (prime_hit),
        .d_o    (div3_hit)
    );

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lo_q        <= 4'd0;
            hi_q        <= 4'd0;
            cur_q       <= 4'd0;
            prime_cnt_q <= '0;
            div3_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            cur_q       <= cur_d;
            prime_cnt_q <= prime_cnt_d;
            div3_cnt_q  <= div3_cnt_d;
            err_q       <= err_d;
        end
    end

    // Next-state and datapath updates; every register holds unless a state
    // says otherwise, so IDLE keeps the last results visible.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        cur_d       = cur_q;
        prime_cnt_d = prime_cnt_q;
        div3_cnt_d  = div3_cnt_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                // abort is meaningless here, so start always wins.
                if (start) begin
                    lo_d        = lo;
                    hi_d        = hi;
                    prime_cnt_d = '0;
                    div3_cnt_d  = '0;
                    err_d       = 1'b0;
                    state_d     = CHECK;
                end
            end

            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (range_bad(lo_q, hi_q, MAX_CODE_4)) begin
                    // Counts were cleared on acceptance and stay at zero.
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cur_d   = lo_q;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                // The current code is always counted, even when aborting.
                prime_cnt_d = prime_cnt_q + W_CNT'(prime_hit);
                div3_cnt_d  = div3_cnt_q + W_CNT'(div3_hit);
                if (abort) begin
                    state_d = IDLE;
                end else if (cur_q == hi_q) begin
                    state_d = DONE;
                end else begin
                    // hi_q <= MAX_CODE was proven in CHECK, so no wrap.
                    cur_d = cur_q + 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = (state_q == CHECK) || (state_q == SCAN);
        done = (state_q == DONE);
    end

    assign err       = err_q;
    assign cur       = cur_q;
    assign prime_cnt = prime_cnt_q;
    assign div3_cnt  = div3_cnt_q;

endmodule

// File: tb/tb_orange_class_seq.sv
// Bench for orange_class_seq: a transaction-level model turns each request
// into the per-cycle output trajectory it must produce, and one compare
// process checks every cycle against it. Directed cases pin literal values.
module tb_orange_class_seq;

    localparam int W = 4;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] cur;
        logic [3:0] pc;
        logic [3:0] dc;
    } obs_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [3:0]   lo;
    logic [3:0]   hi;
    logic         busy;
    logic         done;
    logic         err;
    logic [3:0]   cur;
    logic [W-1:0] prime_cnt;
    logic [W-1:0] div3_cnt;

    logic [3:0]   unit_code;
    logic         unit_p;
    logic         unit_d;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;
    obs_t exp_q[$];
    obs_t mdl;

    orange_class_seq #(.W_CNT(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .lo        (lo),
        .hi        (hi),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cur       (cur),
        .prime_cnt (prime_cnt),
        .div3_cnt  (div3_cnt)
    );

    orange_digit_class u_unit (
        .code_i (unit_code),
        .p_o    (unit_p),
        .d_o    (unit_d)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference rules ----------------
    function automatic bit is_prime(input int c);
        return (c == 2) || (c == 3) || (c == 5) || (c == 7) || (c == 11);
    endfunction

    function automatic bit is_div3(input int c);
        return (c == 3) || (c == 6) || (c == 9);
    endfunction

    function automatic int cnt_p(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) n += is_prime(c);
        return n;
    endfunction

    function automatic int cnt_d(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) n += is_div3(c);
        return n;
    endfunction

    function automatic obs_t mk(input bit b, input bit d, input bit e,
                                input int c, input int p, input int q);
        obs_t o;
        o.busy = b;
        o.done = d;
        o.err  = e;
        o.cur  = 4'(c);
        o.pc   = 4'(p);
        o.dc   = 4'(q);
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            obs_t e;
            obs_t a;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : mdl;
            a = {busy, done, err, cur, prime_cnt, div3_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t: got busy=%b done=%b err=%b cur=%0d p=%0d d=%0d expected busy=%b done=%b err=%b cur=%0d p=%0d d=%0d",
                         $time, a.busy, a.done, a.err, a.cur, a.pc, a.dc,
                         e.busy, e.done, e.err, e.cur, e.pc, e.dc);
            end
        end
    end

    // ---------------- driver ----------------
    // ak: -2 no abort, -1 abort in CHECK, k>=0 abort while cur == l+k.
    task automatic run_txn(input int l, input int h, input int ak, input bit noisy,
                           output int done_cyc, output int busy_cnt);
        int   n;
        int   last_len;
        bit   bad;
        bit   do_abort;
        @(posedge clk); #1;
        start = 1'b1;
        lo    = 4'(l);
        hi    = 4'(h);
        abort = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;

        n        = h - l + 1;
        bad      = (l > h) || (h > 11);
        do_abort = (ak == -1) || (ak >= 0 && !bad && ak < n);
        exp_q.push_back(mk(1, 0, 0, mdl.cur, 0, 0));
        if (ak == -1) begin
            last_len = 1;
            mdl = mk(0, 0, 0, mdl.cur, 0, 0);
        end else if (bad) begin
            last_len = 2;
            exp_q.push_back(mk(0, 1, 1, mdl.cur, 0, 0));
            mdl = mk(0, 0, 1, mdl.cur, 0, 0);
        end else begin
            int stop = do_abort ? ak : n - 1;
            for (int i = 0; i <= stop; i++)
                exp_q.push_back(mk(1, 0, 0, l + i, cnt_p(l, l + i - 1), cnt_d(l, l + i - 1)));
            if (do_abort) begin
                last_len = 2 + ak;
                mdl = mk(0, 0, 0, l + ak, cnt_p(l, l + ak), cnt_d(l, l + ak));
            end else begin
                last_len = n + 2;
                exp_q.push_back(mk(0, 1, 0, h, cnt_p(l, h), cnt_d(l, h)));
                mdl = mk(0, 0, 0, h, cnt_p(l, h), cnt_d(l, h));
            end
        end

        done_cyc = -1;
        busy_cnt = 0;
        for (int c = 1; c <= last_len; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) begin
                lo = 4'($urandom_range(0, 15));
                hi = 4'($urandom_range(0, 15));
            end
            if (do_abort)
                abort = (c == last_len);
            else
                abort = (noisy && c == last_len) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        @(posedge clk); #1;
        start = 1'b0;
        abort = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic check_final(input string name, input int exp_done, input int exp_err,
                               input int exp_cur, input int exp_p, input int exp_d,
                               input int done_cyc);
        check({name, "_done_cycle"}, done_cyc, exp_done);
        check({name, "_err"}, err, exp_err);
        check({name, "_cur"}, cur, exp_cur);
        check({name, "_prime_cnt"}, prime_cnt, exp_p);
        check({name, "_div3_cnt"}, div3_cnt, exp_d);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int dc;
        int bc;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        lo        = 4'd0;
        hi        = 4'd0;
        unit_code = 4'd0;
        mdl       = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, err, cur, prime_cnt, div3_cnt}, 0);
        rst_n = 1'b1;
        #1 chk_en = 1'b1;

        // Range errors straight after reset: cur stays at 0.
        run_txn(7, 4, -2, 0, dc, bc);
        check_final("err_reversed", 2, 1, 0, 0, 0, dc);
        run_txn(0, 13, -2, 0, dc, bc);
        check_final("err_hi_too_big", 2, 1, 0, 0, 0, dc);

        // Full range.
        run_txn(0, 11, -2, 0, dc, bc);
        check_final("full_range", 14, 0, 11, 5, 3, dc);
        check("full_range_busy_cycles", bc, 13);

        // Single code.
        run_txn(3, 3, -2, 0, dc, bc);
        check_final("single_3", 3, 0, 3, 1, 1, dc);

        // Abort when cur=5, with start noise during the scan.
        run_txn(0, 11, 5, 1, dc, bc);
        check_final("abort_at_5", -1, 0, 5, 3, 1, dc);

        // Asynchronous reset in the middle of a scan (cur=6).
        @(posedge clk); #1;
        start = 1'b1; lo = 4'd0; hi = 4'd11; abort = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b0;
        start  = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        check("midscan_cur_before_reset", cur, 6);
        rst_n = 1'b0;
        #1;
        check("midscan_async_reset", {busy, done, err, cur, prime_cnt, div3_cnt}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        mdl = '0;
        #1 chk_en = 1'b1;
        run_txn(9, 11, -2, 0, dc, bc);
        check_final("after_reset_9_11", 5, 0, 11, 1, 1, dc);

        // Randomized requests checked by the per-cycle scoreboard.
        for (int t = 0; t < 60; t++) begin
            int l;
            int h;
            int ak;
            l = $urandom_range(0, 15);
            if (l <= 11 && $urandom_range(0, 3) != 0) h = $urandom_range(11, l);
            else h = $urandom_range(0, 15);
            ak = -2;
            if ($urandom_range(0, 3) == 0) begin
                if (l > h || h > 11) ak = -1;
                else ak = $urandom_range(0, h - l + 1) - 1;
            end
            run_txn(l, h, ak, 1, dc, bc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);

        // Classifier truth table, all sixteen codes.
        for (int c = 0; c < 16; c++) begin
            unit_code = 4'(c);
            #1;
            check($sformatf("class_p_%0d", c), unit_p, is_prime(c));
            check($sformatf("class_d_%0d", c), unit_d, is_div3(c));
        end

        chk_en = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
